// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, with a load watchdog.
// Optional feature macro UART_ARB_LOCK_EN adds i_Lock so a locked owner streams bytes without re-arbitration.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [NUM_REQ*8-1:0] i_Byte,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   i_Lock,
`endif
    output logic [NUM_REQ-1:0]   o_Gnt,
    output logic [NUM_REQ-1:0]   o_Done,
    output logic                 o_Err,
    output logic                 o_Tx_Ready,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic [IDX_W-1:0]     o_Owner
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic             WDOG_EN  = (TIMEOUT_CYC != 0);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic               err_d, tx_ready_d, busy_d;
    logic [7:0]         tx_byte_d;
    logic [IDX_W-1:0]   owner_d;

    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_oh;
    logic [7:0]         sel_byte;
    logic [NUM_REQ-1:0] owner_oh;
`ifdef UART_ARB_LOCK_EN
    logic [7:0]         owner_byte;
    logic               owner_req;
    logic               owner_lock;
`endif

    // Round-robin pick: first request above last, otherwise first at or below last.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = last_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!sel_vld && i_Req[k] && (IDX_W'(k) > last_q)) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!sel_vld && i_Req[k] && (IDX_W'(k) <= last_q)) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(k);
            end
        end
    end

    // Decode selected and owning source into one-hot vectors and byte lanes.
    always_comb begin
        sel_oh   = '0;
        sel_byte = '0;
        owner_oh = '0;
`ifdef UART_ARB_LOCK_EN
        owner_byte = '0;
        owner_req  = 1'b0;
        owner_lock = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_oh[k] = 1'b1;
                sel_byte  = i_Byte[8*k +: 8];
            end
            if (IDX_W'(k) == o_Owner) begin
                owner_oh[k] = 1'b1;
`ifdef UART_ARB_LOCK_EN
                owner_byte = i_Byte[8*k +: 8];
                owner_req  = i_Req[k];
                owner_lock = i_Lock[k];
`endif
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        tx_ready_d = o_Tx_Ready;
        tx_byte_d  = o_Tx_Byte;
        owner_d    = o_Owner;

        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d      = sel_oh;
                    tx_ready_d = 1'b1;
                    tx_byte_d  = sel_byte;
                    owner_d    = sel_idx;
                    last_d     = sel_idx;
                    cnt_d      = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                if (i_Tx_Done) begin
                    tx_ready_d = 1'b0;
                    done_d     = owner_oh;
                    state_d    = IDLE;
`ifdef UART_ARB_LOCK_EN
                    if (owner_lock && owner_req) begin
                        gnt_d      = owner_oh;
                        tx_ready_d = 1'b1;
                        tx_byte_d  = owner_byte;
                        cnt_d      = '0;
                        state_d    = LOAD;
                    end
`endif
                end else if (i_Tx_Active) begin
                    tx_ready_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    // Transmitter never took the byte: reclaim it without a done.
                    tx_ready_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    done_d  = owner_oh;
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    if (owner_lock && owner_req) begin
                        gnt_d      = owner_oh;
                        tx_ready_d = 1'b1;
                        tx_byte_d  = owner_byte;
                        cnt_d      = '0;
                        state_d    = LOAD;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            o_Gnt      <= '0;
            o_Done     <= '0;
            o_Err      <= 1'b0;
            o_Tx_Ready <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Busy     <= 1'b0;
            o_Owner    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            o_Gnt      <= gnt_d;
            o_Done     <= done_d;
            o_Err      <= err_d;
            o_Tx_Ready <= tx_ready_d;
            o_Tx_Byte  <= tx_byte_d;
            o_Busy     <= busy_d;
            o_Owner    <= owner_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random requesters and transmitter against an event-level model.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TB_TO   = 8;
    localparam int          NR      = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req;
    logic [7:0]           req_byte [NR];
    logic [NUM_REQ*8-1:0] byte_bus;
    logic                 tx_active, tx_done;
    logic [NUM_REQ-1:0]   o_gnt, o_done;
    logic                 o_err, o_tx_ready, o_busy;
    logic [7:0]           o_tx_byte;
    logic [IDX_W-1:0]     o_owner;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   lock = '0;
`endif

    always #5 clk = ~clk;

    always_comb begin
        byte_bus = '0;
        for (int k = 0; k < NR; k++) byte_bus[8*k +: 8] = req_byte[k];
    end

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Req       (req),
        .i_Byte      (byte_bus),
`ifdef UART_ARB_LOCK_EN
        .i_Lock      (lock),
`endif
        .o_Gnt       (o_gnt),
        .o_Done      (o_done),
        .o_Err       (o_err),
        .o_Tx_Ready  (o_tx_ready),
        .o_Tx_Byte   (o_tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Busy      (o_busy),
        .o_Owner     (o_owner)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},      32'(o_gnt),      0);
        check({tag, "_done"},     32'(o_done),     0);
        check({tag, "_err"},      32'(o_err),      0);
        check({tag, "_tx_ready"}, 32'(o_tx_ready), 0);
        check({tag, "_tx_byte"},  32'(o_tx_byte),  0);
        check({tag, "_busy"},     32'(o_busy),     0);
        check({tag, "_owner"},    32'(o_owner),    0);
    endtask

    // Expected output events, stamped with the cycle in which they must be visible.
    typedef enum int {EV_GNT, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        int         cyc;
        ev_kind_t   kind;
        int         idx;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: who holds the transmitter, whether the byte is still unaccepted, and for how long.
    int         cyc       = 0;
    bit         m_busy    = 1'b0;
    bit         m_loading = 1'b0;
    int         m_owner   = 0;
    int         m_last    = NR - 1;
    int         m_age     = 0;
    int         m_pick;
    logic [7:0] m_byte    = 8'h00;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_busy = 1'b0; m_loading = 1'b0; m_owner = 0; m_last = NR - 1; m_byte = 8'h00;
        end else if (!m_busy) begin
            m_pick = -1;
            for (int d = 1; d <= NR; d++)
                if (m_pick < 0 && req[(m_last + d) % NR]) m_pick = (m_last + d) % NR;
            if (m_pick >= 0) begin
                m_owner = m_pick; m_last = m_pick; m_byte = req_byte[m_pick];
                m_busy = 1'b1; m_loading = 1'b1; m_age = 0;
                exp_q.push_back('{cyc: cyc, kind: EV_GNT, idx: m_pick, data: m_byte});
            end
        end else if (m_loading) begin
            if (tx_done) begin
                m_busy = 1'b0; m_loading = 1'b0;
                exp_q.push_back('{cyc: cyc, kind: EV_DONE, idx: m_owner, data: 8'h00});
            end else if (tx_active) begin
                m_loading = 1'b0;
            end else begin
                m_age++;
                if (m_age == int'(TB_TO)) begin
                    m_busy = 1'b0; m_loading = 1'b0;
                    exp_q.push_back('{cyc: cyc, kind: EV_ERR, idx: m_owner, data: 8'h00});
                end
            end
        end else if (tx_done) begin
            m_busy = 1'b0;
            exp_q.push_back('{cyc: cyc, kind: EV_DONE, idx: m_owner, data: 8'h00});
        end
    end

    // Monitor: pop this cycle's expected events and compare against what the DUT presents.
    ev_t                ev;
    logic [NUM_REQ-1:0] e_gnt, e_done;
    logic               e_err;
    logic [7:0]         e_byte;

    always @(negedge clk) begin
        if (cyc > 0) begin
            e_gnt = '0; e_done = '0; e_err = 1'b0; e_byte = m_byte;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                ev = exp_q.pop_front();
                case (ev.kind)
                    EV_GNT:  begin e_gnt[ev.idx] = 1'b1; e_byte = ev.data; end
                    EV_DONE: e_done[ev.idx] = 1'b1;
                    default: e_err = 1'b1;
                endcase
            end
            if (o_gnt != 0 || e_gnt != 0) begin
                check("gnt", 32'(o_gnt), 32'(e_gnt));
                check("gnt_byte", 32'(o_tx_byte), 32'(e_byte));
            end
            if (o_done != 0 || e_done != 0) check("done", 32'(o_done), 32'(e_done));
            if (o_err || e_err) check("err", 32'(o_err), 32'(e_err));
            check("tx_ready", 32'(o_tx_ready), 32'(m_loading));
            check("busy",     32'(o_busy),     32'(m_busy));
            check("owner",    32'(o_owner),    32'(m_owner));
            check("tx_byte",  32'(o_tx_byte),  32'(m_byte));
        end
    end

    // Transmitter model: accepts after a delay, completes in LOAD, or never answers.
    int tx_phase   = 0;
    int tx_cnt     = 0;
    bit tx_fast    = 1'b0;
    bit tx_both    = 1'b0;
    bit tx_no_hang = 1'b0;
    bit req_cont   = 1'b0;

    task automatic tx_step();
        int mode;
        tx_done = 1'b0;
        if (tx_phase == 4) begin tx_active = 1'b0; tx_phase = 0; end
        if (tx_phase == 3 && !o_tx_ready) tx_phase = 0;
        if (tx_phase == 0) begin
            tx_active = 1'b0;
            if (o_tx_ready) begin
                mode = int'($urandom_range(0, 7));
                if (mode == 0 && !tx_no_hang) tx_phase = 3;
                else begin
                    tx_fast  = (mode == 1 || mode == 2);
                    tx_both  = (mode == 1);
                    tx_cnt   = int'($urandom_range(0, 4));
                    tx_phase = 1;
                end
            end
        end
        if (tx_phase == 1) begin
            if (tx_cnt == 0) begin
                if (tx_fast) begin tx_active = tx_both; tx_done = 1'b1; tx_phase = 4; end
                else begin tx_active = 1'b1; tx_cnt = int'($urandom_range(1, 5)); tx_phase = 2; end
            end else tx_cnt--;
        end else if (tx_phase == 2) begin
            if (tx_cnt == 0) begin tx_done = 1'b1; tx_active = 1'b0; tx_phase = 0; end
            else begin tx_cnt--; tx_active = ($urandom_range(0, 3) != 0); end
        end
    endtask

    task automatic req_step();
        for (int k = 0; k < NR; k++) begin
            if (req[k] && o_gnt[k]) begin
                if (req_cont || $urandom_range(0, 2) == 0) req_byte[k] = 8'($urandom);
                else req[k] = 1'b0;
            end else if (!req[k]) begin
                if (!req_cont && $urandom_range(0, 5) == 0) begin
                    req[k] = 1'b1;
                    req_byte[k] = 8'($urandom);
                end
            end else if (!req_cont && $urandom_range(0, 63) == 0) begin
                req[k] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        req = '0;
        while ((o_busy || tx_phase != 0) && w < 100) begin
            @(negedge clk);
            tx_step();
            w++;
        end
        check({tag, "_drain_bound"}, 32'(w < 100), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int order[$];
        reset_n = 1'b0; req = '0; tx_active = 1'b0; tx_done = 1'b0;
        for (int k = 0; k < NR; k++) req_byte[k] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tx_step();
            req_step();
        end
        drain("rand");

        // Single source through a full frame.
        @(negedge clk); req[2] = 1'b1; req_byte[2] = 8'hA5;
        @(negedge clk);
        check("single_gnt",   32'(o_gnt), 32'h4);
        check("single_byte",  32'(o_tx_byte), 32'hA5);
        check("single_ready", 32'(o_tx_ready), 1);
        req[2] = 1'b0; tx_active = 1'b1;
        @(negedge clk);
        check("single_wait_ready", 32'(o_tx_ready), 0);
        tx_active = 1'b0; tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("single_done", 32'(o_done), 32'h4);
        check("single_idle", 32'(o_busy), 0);

        // Done and active together while loading.
        req[1] = 1'b1; req_byte[1] = 8'h3C;
        @(negedge clk);
        check("dil_gnt", 32'(o_gnt), 32'h2);
        req[1] = 1'b0; tx_active = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        tx_active = 1'b0; tx_done = 1'b0;
        check("dil_done", 32'(o_done), 32'h2);
        check("dil_idle", 32'(o_busy), 0);

        // Watchdog abort, then the waiting requester is served.
        req[3] = 1'b1; req_byte[3] = 8'h5A;
        @(negedge clk);
        check("wd_gnt", 32'(o_gnt), 32'h8);
        req[3] = 1'b0; req[0] = 1'b1; req_byte[0] = 8'hC3;
        n = 0;
        while (!o_err && n < 20) begin @(negedge clk); n++; end
        check("wd_latency", 32'(n), 32'(TB_TO));
        check("wd_ready",   32'(o_tx_ready), 0);
        check("wd_no_done", 32'(o_done), 0);
        @(negedge clk);
        check("wd_next_gnt",  32'(o_gnt), 32'h1);
        check("wd_next_byte", 32'(o_tx_byte), 32'hC3);

        // Reset in the middle of a frame.
        req[0] = 1'b0; tx_active = 1'b1;
        @(negedge clk);
        check("mf_busy",  32'(o_busy), 1);
        check("mf_ready", 32'(o_tx_ready), 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        tx_active = 1'b0; reset_n = 1'b1;

        // Round-robin with every source requesting continuously.
        req_cont = 1'b1; tx_no_hang = 1'b1;
        for (int k = 0; k < NR; k++) begin req[k] = 1'b1; req_byte[k] = 8'($urandom); end
        n = 0;
        while (order.size() < 6 && n < 300) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) if (o_gnt[k]) order.push_back(k);
            tx_step();
            req_step();
            n++;
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_order_%0d", i), 32'((i < order.size()) ? order[i] : -1), 32'(i % NR));
        req_cont = 1'b0;
        drain("rr");

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit controller between `NUM_REQ` byte sources on the system clock. It picks one requester round-robin, captures its byte, drives the transmitter's ready/byte inputs, and tracks the transmitter's active/done status until the frame completes. It sits between the client logic and the `uart_controller` TX path. It adds a watchdog that reclaims the transmitter if a load is never accepted.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `IDX_W`, 2: owner index width, must be ≥ clog2(`NUM_REQ`).
- `TIMEOUT_CYC`, 4096: clk cycles allowed in LOAD before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `i_Req`  in  NUM_REQ  level request per source; bit k's byte is on `i_Byte[8k+7:8k]`.
- `i_Byte`  in  NUM_REQ*8  packed bytes.
- `o_Gnt`  out  NUM_REQ  one-hot, 1-cycle pulse: byte of source k has been captured.
- `o_Done`  out  NUM_REQ  one-hot, 1-cycle pulse: source k's frame has finished.
- `o_Err`  out  1  1-cycle pulse on watchdog abort.
- `o_Tx_Ready`  out  1  load request to the transmitter.
- `o_Tx_Byte`  out  8  byte to the transmitter.
- `i_Tx_Active`  in  1  transmitter busy, synchronized to `clk`.
- `i_Tx_Done`  in  1  frame-complete pulse, synchronized to `clk`.
- `o_Busy`  out  1  FSM not in IDLE.
- `o_Owner`  out  IDX_W  index of the current/last grantee.

## Operation
States: IDLE, LOAD, WAIT_DONE.

IDLE
- If `i_Req` != 0, select the first set bit searching from `last+1` upward, wrapping at `NUM_REQ-1` to 0.
- Register the selected byte into `o_Tx_Byte` and set `o_Owner` and `last` to the selected index.
- Pulse `o_Gnt[sel]`, set `o_Tx_Ready` = 1, clear the watchdog counter, and go to LOAD.
- After reset, `last` = `NUM_REQ-1`, so index 0 wins first.

LOAD
- Hold `o_Tx_Ready` = 1 and `o_Tx_Byte` stable.
- On `i_Tx_Active` = 1: clear `o_Tx_Ready` and go to WAIT_DONE.
- On `i_Tx_Done` = 1 (takes precedence over `i_Tx_Active`): clear `o_Tx_Ready`, pulse `o_Done[owner]`, and go to IDLE.
- If `TIMEOUT_CYC` != 0 and the counter reaches `TIMEOUT_CYC-1`: clear `o_Tx_Ready`, pulse `o_Err`, and go to IDLE. No `o_Done` is issued.

WAIT_DONE
- On `i_Tx_Done`: pulse `o_Done[owner]` and go to IDLE.
- `i_Tx_Active` falling without `i_Tx_Done` is ignored.

Requests
- A requester keeps `i_Req` and its byte stable until it sees `o_Gnt`; it may change both afterwards.
- A request dropped before its grant is never granted. No byte is consumed.
- `i_Req` changes outside IDLE are ignored.

Watchdog counter
- Width is clog2(`TIMEOUT_CYC`+1) and it saturates.
- It counts only in LOAD.

## Timing
- Reset values: `o_Gnt` = 0, `o_Done` = 0, `o_Err` = 0, `o_Tx_Ready` = 0, `o_Tx_Byte` = 8'h00, `o_Busy` = 0, `o_Owner` = 0.
- Grant latency: a request present in IDLE at edge n gives `o_Gnt`, `o_Tx_Ready` and `o_Tx_Byte` valid after edge n+1.
- `o_Done` is asserted the cycle after the `i_Tx_Done` edge; IDLE is re-entered in that same cycle.
- Back-to-back: the next grant can occur one cycle after `o_Done`. Minimum gap between `o_Done` and the next `o_Tx_Ready` is 1 cycle.
- `reset_n` = 0 at any edge, including mid-frame, forces IDLE and all reset values on the next edge. The transmitter is not otherwise notified.
- All outputs are registered.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Adds input `i_Lock` [NUM_REQ-1:0].
  - In WAIT_DONE (or LOAD completing via `i_Tx_Done`), if `i_Lock[owner]` && `i_Req[owner]`, go directly to LOAD with that owner's new byte, pulsing `o_Done` and `o_Gnt` for the owner in the same cycle. This lets multi-byte packets go without interleaving.
  - A lock expires after the owner's `i_Req` drops; arbitration then resumes at `owner+1`.
- Undefined: no `i_Lock` port; every byte re-arbitrates.

## Test plan
- Single source: `i_Req` = 4'b0100, byte 8'hA5 → `o_Gnt` = 4'b0100 and `o_Tx_Byte` = A5 after 1 cycle; `i_Tx_Active` then `i_Tx_Done` → `o_Done` = 4'b0100, FSM returns to IDLE.
- Round-robin: all four request continuously, TX model completes each frame → grant order 0, 1, 2, 3, 0, 1.
- Watchdog: `TIMEOUT_CYC` = 8, `i_Tx_Active` held low → `o_Err` pulses 8 cycles after the grant, `o_Tx_Ready` drops, no `o_Done`; the next requester is granted.
- Done in LOAD: `i_Tx_Done` and `i_Tx_Active` asserted together in LOAD → single `o_Done`, IDLE, no WAIT_DONE visit.
- Reset mid-frame: `reset_n` = 0 in WAIT_DONE → all outputs at reset values next cycle; first post-reset grant goes to index 0.
- With `UART_ARB_LOCK_EN`: source 1 locked, sending 3 bytes while source 2 requests → source 1's 3 bytes go consecutively, then source 2 is granted.
